seg7_multi_display: RTL and testbench

- Parametrised N-digit 7-segment driver for DE10-Lite HEX displays (active-low segments).
- Accepts a DATA_W-bit value through a load handshake and shows it in hex or decimal.
- Decimal mode uses a sequential double-dabble converter, one bit per clock.
- Adds per-digit decimal points, overflow indication and busy/done status.
- Sits between arithmetic result producers (e.g. multiplier output) and the board HEX pins.

---
 rtl/seg7_multi_display.sv | 167 ++++++++++++++++
 tb/tb_seg7_multi_display.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/seg7_multi_display.sv
// seg7_multi_display
//   N-digit active-low 7-segment driver for the DE10-Lite HEX displays.
//   A value is captured through a load handshake and shown either in hex
//   (one nibble per digit) or in unsigned decimal. Decimal conversion is a
//   sequential double-dabble, one input bit per clock.
//
//   State table:
//     IDLE   | waiting for load; seg holds the last result
//     CONV   | double-dabble, DATA_W cycles, one bit shifted per cycle
//     ENCODE | one cycle; seg/ovf written, done pulsed, busy dropped
//
//   Optional build macro: SEG7_LZ_BLANK_EN
//     defined   -> leading-zero digits are blanked (digit 0 always shown)
//     undefined -> every digit always shows a glyph
//
//   Ports:
//     clk      in   system clock, rising edge
//     rst      in   asynchronous reset, active high
//     load     in   capture value/mode/dp_mask (ignored while busy)
//     value    in   [DATA_W-1:0] number to display
//     mode     in   0 = hex, 1 = unsigned decimal
//     dp_mask  in   [NUM_DIGITS-1:0] per-digit decimal point enable
//     seg      out  [8*NUM_DIGITS-1:0] {dp,g,f,e,d,c,b,a} per digit, active low
//     busy     out  a load is being processed
//     done     out  one-cycle pulse when seg is written
//     ovf      out  value did not fit; held until next result is written
module seg7_multi_display #(
  parameter int DATA_W     = 16,
  parameter int NUM_DIGITS = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [DATA_W-1:0]       value,
  input  logic                    mode,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  output logic [8*NUM_DIGITS-1:0] seg,
  output logic                    busy,
  output logic                    done,
  output logic                    ovf
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {IDLE, CONV, ENCODE} state_t;

  state_t                  state;
  logic [BCD_W-1:0]        bcd;
  logic [DATA_W-1:0]       bin;
  logic [NUM_DIGITS-1:0]   dp_r;
  logic [CNT_W-1:0]        cnt;
  logic                    ovf_pend;

  // Zero-extended value: the low BCD_W bits feed the hex digits, anything
  // above them means the value cannot be shown in NUM_DIGITS hex digits.
  logic [DATA_W+BCD_W-1:0] ext;
  logic                    hex_ovf;
  assign ext     = {{BCD_W{1'b0}}, value};
  assign hex_ovf = |ext[DATA_W+BCD_W-1:BCD_W];

  function automatic logic [7:0] hex_glyph(input logic [3:0] n);
    case (n)
      4'h0: hex_glyph = 8'hC0;  4'h1: hex_glyph = 8'hF9;
      4'h2: hex_glyph = 8'hA4;  4'h3: hex_glyph = 8'hB0;
      4'h4: hex_glyph = 8'h99;  4'h5: hex_glyph = 8'h92;
      4'h6: hex_glyph = 8'h82;  4'h7: hex_glyph = 8'hF8;
      4'h8: hex_glyph = 8'h80;  4'h9: hex_glyph = 8'h90;
      4'hA: hex_glyph = 8'h88;  4'hB: hex_glyph = 8'h83;
      4'hC: hex_glyph = 8'hC6;  4'hD: hex_glyph = 8'hA1;
      4'hE: hex_glyph = 8'h86;  default: hex_glyph = 8'h8E;
    endcase
  endfunction

  // Double-dabble correction step ahead of each shift.
  logic [BCD_W-1:0] bcd_adj;
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // Glyph encoding; bcd holds either the hex nibbles or the decimal digits.
  logic [8*NUM_DIGITS-1:0] seg_next;
  logic [7:0]              glyph;
  logic [3:0]              nib;
`ifdef SEG7_LZ_BLANK_EN
  logic                    lead;
`endif
  always_comb begin
    seg_next = '1;
    glyph    = 8'hFF;
    nib      = 4'h0;
`ifdef SEG7_LZ_BLANK_EN
    lead     = 1'b1;
`endif
    // Walk from the top digit so the leading-zero flag can propagate down.
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nib = bcd[4*i +: 4];
      if (ovf_pend) begin
        glyph = 8'hBF;
      end else begin
        glyph = hex_glyph(nib);
`ifdef SEG7_LZ_BLANK_EN
        if (lead && (nib == 4'h0) && (i != 0)) glyph = 8'hFF;
        if (nib != 4'h0) lead = 1'b0;
`endif
      end
      if (dp_r[i]) glyph[7] = 1'b0;
      seg_next[8*i +: 8] = glyph;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      bcd      <= '0;
      bin      <= '0;
      dp_r     <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
      seg      <= '1;
      busy     <= 1'b0;
      done     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            dp_r <= dp_mask;
            busy <= 1'b1;
            if (mode) begin
              bcd      <= '0;
              bin      <= value;
              ovf_pend <= 1'b0;
              cnt      <= CNT_W'(DATA_W - 1);
              state    <= CONV;
            end else begin
              bcd      <= ext[BCD_W-1:0];
              ovf_pend <= hex_ovf;
              state    <= ENCODE;
            end
          end
        end
        CONV: begin
          bcd <= {bcd_adj[BCD_W-2:0], bin[DATA_W-1]};
          bin <= bin << 1;
          // A carry out of the top BCD digit means more digits were needed.
          if (bcd_adj[BCD_W-1]) ovf_pend <= 1'b1;
          cnt <= cnt - CNT_W'(1);
          if (cnt == '0) state <= ENCODE;
        end
        ENCODE: begin
          seg   <= seg_next;
          ovf   <= ovf_pend;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_multi_display.sv
module tb_seg7_multi_display;

`ifdef SEG7_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        load6 = 1'b0, mode6 = 1'b0;
  logic [15:0] value6 = '0;
  logic [5:0]  dp6 = '0;
  logic [47:0] seg6;
  logic        busy6, done6, ovf6;

  logic        load4 = 1'b0, mode4 = 1'b0;
  logic [15:0] value4 = '0;
  logic [3:0]  dp4 = '0;
  logic [31:0] seg4;
  logic        busy4, done4, ovf4;

  int nerr = 0;
  int nchk = 0;

  always #5 clk = ~clk;

  seg7_multi_display u6 (
    .clk(clk), .rst(rst), .load(load6), .value(value6), .mode(mode6),
    .dp_mask(dp6), .seg(seg6), .busy(busy6), .done(done6), .ovf(ovf6)
  );

  seg7_multi_display #(.DATA_W(16), .NUM_DIGITS(4)) u4 (
    .clk(clk), .rst(rst), .load(load4), .value(value4), .mode(mode4),
    .dp_mask(dp4), .seg(seg4), .busy(busy4), .done(done4), .ovf(ovf4)
  );

  typedef struct {
    bit          d4;
    logic [15:0] value;
    bit          mode;
    logic [5:0]  dp;
    logic [47:0] exp_seg;
    bit          exp_ovf;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int  lat;
    bit  hold_ok;
    @(negedge clk);
    if (v.d4) begin
      load4 = 1'b1; value4 = v.value; mode4 = v.mode; dp4 = v.dp[3:0];
    end else begin
      load6 = 1'b1; value6 = v.value; mode6 = v.mode; dp6 = v.dp;
    end
    @(negedge clk);
    load4 = 1'b0;
    load6 = 1'b0;
    chk({tag, " busy_start"}, v.d4 ? busy4 : busy6, 1);
    lat = 0;
    hold_ok = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (v.d4 ? done4 : done6) begin
        lat = k;
        break;
      end
      if (!(v.d4 ? busy4 : busy6)) hold_ok = 1'b0;
    end
    chk({tag, " latency"}, lat, v.mode ? 17 : 1);
    chk({tag, " busy_hold"}, hold_ok, 1);
    if (v.d4) chk({tag, " seg"}, seg4, v.exp_seg[31:0]);
    else      chk({tag, " seg"}, seg6, v.exp_seg);
    chk({tag, " ovf"}, v.d4 ? ovf4 : ovf6, v.exp_ovf);
    chk({tag, " busy_end"}, v.d4 ? busy4 : busy6, 0);
    @(negedge clk);
    chk({tag, " done_pulse"}, v.d4 ? done4 : done6, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  lat;
    bit  never;
    vec_t v;

    vecs[0]  = '{0, 16'hF3A1, 0, 6'b000000, LZ ? 48'hFFFF8EB088F9 : 48'hC0C08EB088F9, 0};
    vecs[1]  = '{0, 16'd65535, 1, 6'b000000, LZ ? 48'hFF829292B092 : 48'hC0829292B092, 0};
    vecs[2]  = '{0, 16'h0007, 0, 6'b000010, LZ ? 48'hFFFFFFFF7FF8 : 48'hC0C0C0C040F8, 0};
    vecs[3]  = '{0, 16'd42, 1, 6'b000000, LZ ? 48'hFFFFFFFF99A4 : 48'hC0C0C0C099A4, 0};
    vecs[4]  = '{0, 16'd0, 1, 6'b000000, LZ ? 48'hFFFFFFFFFFC0 : 48'hC0C0C0C0C0C0, 0};
    vecs[5]  = '{0, 16'h0000, 0, 6'b111111, LZ ? 48'h7F7F7F7F7F40 : 48'h404040404040, 0};
    vecs[6]  = '{0, 16'd1000, 1, 6'b100001, LZ ? 48'h7FFFF9C0C040 : 48'h40C0F9C0C040, 0};
    vecs[7]  = '{0, 16'h89AB, 0, 6'b000000, LZ ? 48'hFFFF80908883 : 48'hC0C080908883, 0};
    vecs[8]  = '{0, 16'h4C5E, 0, 6'b000000, LZ ? 48'hFFFF99C69286 : 48'hC0C099C69286, 0};
    vecs[9]  = '{0, 16'h62D0, 0, 6'b000000, LZ ? 48'hFFFF82A4A1C0 : 48'hC0C082A4A1C0, 0};
    vecs[10] = '{1, 16'd12345, 1, 6'b000000, 48'h0000BFBFBFBF, 1};
    vecs[11] = '{1, 16'd42, 1, 6'b000000, LZ ? 48'h0000FFFF99A4 : 48'h0000C0C099A4, 0};
    vecs[12] = '{1, 16'd9999, 1, 6'b000000, 48'h000090909090, 0};
    vecs[13] = '{1, 16'hFFFF, 0, 6'b000000, 48'h00008E8E8E8E, 0};
    vecs[14] = '{1, 16'd10000, 1, 6'b001000, 48'h00003FBFBFBF, 1};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst seg6", seg6, 48'hFFFFFFFFFFFF);
    chk("rst seg4", seg4, 32'hFFFFFFFF);
    chk("rst busy", {busy6, busy4}, 2'b00);
    chk("rst done", {done6, done4}, 2'b00);
    chk("rst ovf", {ovf6, ovf4}, 2'b00);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Overflow and display hold between operations
    repeat (5) @(negedge clk);
    chk("hold ovf4", ovf4, 1);
    chk("hold seg4", seg4, 32'h3FBFBFBF);
    chk("hold busy4", busy4, 0);
    v = '{1, 16'h0042, 0, 6'b000000, LZ ? 48'h0000FFFF99A4 : 48'h0000C0C099A4, 0};
    run_vec(v, "ovf_clear");

    // Load while busy must be ignored
    @(negedge clk);
    load6 = 1'b1; value6 = 16'd65535; mode6 = 1'b1; dp6 = '0;
    @(negedge clk);
    load6 = 1'b0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      load6 = 1'b0;
      if (done6) begin
        lat = k;
        break;
      end
      if (k == 5) begin
        load6 = 1'b1; value6 = 16'd1; mode6 = 1'b0;
      end
    end
    chk("ignore latency", lat, 17);
    chk("ignore seg", seg6, LZ ? 48'hFF829292B092 : 48'hC0829292B092);
    @(negedge clk);
    chk("ignore idle", busy6, 0);

    // Reset mid-conversion
    load6 = 1'b1; value6 = 16'd65535; mode6 = 1'b1;
    @(negedge clk);
    load6 = 1'b0;
    repeat (10) @(negedge clk);
    chk("midrst busy_before", busy6, 1);
    rst = 1'b1;
    #1;
    chk("midrst seg", seg6, 48'hFFFFFFFFFFFF);
    chk("midrst busy", busy6, 0);
    chk("midrst done", done6, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    never = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done6 || busy6) never = 1'b0;
    end
    chk("midrst no_done", never, 1);
    chk("midrst seg_after", seg6, 48'hFFFFFFFFFFFF);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
